// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the hazard controller and its helpers.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    ECALL_DRAIN = 2'd1,
    ECALL_WAIT  = 2'd2
  } hazard_state_t;

  localparam int DEFAULT_REG_ID_WIDTH = 5;

  // Register x0 is hardwired to zero, so a load targeting it never creates a hazard.
  localparam int REG_X0 = 0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently sitting in ID/EX.
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ID_WIDTH = DEFAULT_REG_ID_WIDTH
) (
  input  logic [REG_ID_WIDTH-1:0] id_reg1,
  input  logic [REG_ID_WIDTH-1:0] id_reg2,
  input  logic                    id_uses_reg1,
  input  logic                    id_uses_reg2,
  input  logic [REG_ID_WIDTH-1:0] ex_dest,
  input  logic                    ex_mem_read,
  output logic                    load_use
);

  logic dest_nonzero;
  logic match1;
  logic match2;

  assign dest_nonzero = (ex_dest != REG_ID_WIDTH'(REG_X0));
  assign match1       = id_uses_reg1 && (id_reg1 == ex_dest);
  assign match2       = id_uses_reg2 && (id_reg2 == ex_dest);
  assign load_use     = ex_mem_read && dest_nonzero && (match1 || match2);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller: load-use, redirect, memory wait and ecall
// serialization with a watchdog, plus saturating stall/flush statistics.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ID_WIDTH  = DEFAULT_REG_ID_WIDTH,
  parameter int CNT_WIDTH     = 32,
  parameter int ECALL_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REG_ID_WIDTH-1:0] id_reg1,
  input  logic [REG_ID_WIDTH-1:0] id_reg2,
  input  logic                    id_uses_reg1,
  input  logic                    id_uses_reg2,
  input  logic                    id_is_ecall,
  input  logic [REG_ID_WIDTH-1:0] ex_dest,
  input  logic                    ex_mem_read,
  input  logic                    ex_redirect,
  input  logic                    imem_busy,
  input  logic                    dmem_busy,
  input  logic                    wb_ecall_done,
  output logic                    pc_stall,
  output logic                    if_id_stall,
  output logic                    id_ex_stall,
  output logic                    ex_mem_stall,
  output logic                    if_id_flush,
  output logic                    id_ex_flush,
  output logic                    ex_mem_flush,
  output logic                    mem_wb_flush,
  output logic                    ecall_timeout,
  output logic [CNT_WIDTH-1:0]    stall_cycles,
  output logic [CNT_WIDTH-1:0]    flush_events
);

  localparam int WD_W = $clog2(ECALL_TIMEOUT + 1);

  hazard_state_t       state_q, state_d;
  logic                redirect_pending_q, redirect_pending_d;
  logic [WD_W-1:0]     watchdog_q, watchdog_d;
  logic                ecall_timeout_q, ecall_timeout_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] flush_events_q, flush_events_d;

  logic load_use;
  logic pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c;
  logic if_id_flush_c, id_ex_flush_c, mem_wb_flush_c;
  logic any_flush;

  load_use_detect #(
    .REG_ID_WIDTH(REG_ID_WIDTH)
  ) u_load_use_detect (
    .id_reg1     (id_reg1),
    .id_reg2     (id_reg2),
    .id_uses_reg1(id_uses_reg1),
    .id_uses_reg2(id_uses_reg2),
    .ex_dest     (ex_dest),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    pc_stall_c         = 1'b0;
    if_id_stall_c      = 1'b0;
    id_ex_stall_c      = 1'b0;
    ex_mem_stall_c     = 1'b0;
    if_id_flush_c      = 1'b0;
    id_ex_flush_c      = 1'b0;
    mem_wb_flush_c     = 1'b0;
    state_d            = state_q;
    redirect_pending_d = redirect_pending_q;
    watchdog_d         = watchdog_q;
    ecall_timeout_d    = ecall_timeout_q;

    // A data-memory wait freezes everything upstream of MEM, including the FSM.
    if (dmem_busy) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else begin
      if (redirect_pending_q) begin
        if_id_flush_c = 1'b1;
        if (!imem_busy) redirect_pending_d = 1'b0;
      end

      unique case (state_q)
        RUN: begin
          if (ex_redirect) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            if (imem_busy) redirect_pending_d = 1'b1;
          end else if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (id_is_ecall) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            state_d       = ECALL_DRAIN;
          end else if (imem_busy) begin
            pc_stall_c    = 1'b1;
            if_id_flush_c = 1'b1;
          end
        end
        ECALL_DRAIN: begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
          state_d       = ECALL_WAIT;
        end
        ECALL_WAIT: begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
          if (wb_ecall_done) begin
            state_d    = RUN;
            watchdog_d = '0;
          end else if (watchdog_q == WD_W'(ECALL_TIMEOUT - 1)) begin
            ecall_timeout_d = 1'b1;
            state_d         = RUN;
            watchdog_d      = '0;
          end else begin
            watchdog_d = watchdog_q + WD_W'(1);
          end
        end
        default: state_d = RUN;
      endcase

      // IF/ID holds a stale fetch whenever it is flushed, so the flush wins over a hold.
      if (if_id_flush_c) if_id_stall_c = 1'b0;
    end
  end

  assign pc_stall     = reset & pc_stall_c;
  assign if_id_stall  = reset & if_id_stall_c;
  assign id_ex_stall  = reset & id_ex_stall_c;
  assign ex_mem_stall = reset & ex_mem_stall_c;
  assign if_id_flush  = reset & if_id_flush_c;
  assign id_ex_flush  = reset & id_ex_flush_c;
  assign ex_mem_flush = 1'b0;
  assign mem_wb_flush = reset & mem_wb_flush_c;

  assign any_flush = if_id_flush | id_ex_flush | ex_mem_flush | mem_wb_flush;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    if (any_flush && (flush_events_q != '1)) flush_events_d = flush_events_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= RUN;
      redirect_pending_q <= 1'b0;
      watchdog_q         <= '0;
      ecall_timeout_q    <= 1'b0;
      stall_cycles_q     <= '0;
      flush_events_q     <= '0;
    end else begin
      state_q            <= state_d;
      redirect_pending_q <= redirect_pending_d;
      watchdog_q         <= watchdog_d;
      ecall_timeout_q    <= ecall_timeout_d;
      stall_cycles_q     <= stall_cycles_d;
      flush_events_q     <= flush_events_d;
    end
  end

  assign ecall_timeout = ecall_timeout_q;
  assign stall_cycles  = stall_cycles_q;
  assign flush_events  = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (short watchdog, 4-bit counters).
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_reg1, id_reg2, ex_dest;
  logic       id_uses_reg1, id_uses_reg2, id_is_ecall;
  logic       ex_mem_read, ex_redirect, imem_busy, dmem_busy, wb_ecall_done;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       ecall_timeout;
  logic [3:0] stall_cycles, flush_events;
  logic [7:0] ctl;

  int checks = 0;
  int passes = 0;

  hazard_ctrl #(
    .REG_ID_WIDTH (5),
    .CNT_WIDTH    (4),
    .ECALL_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_reg1      (id_reg1),
    .id_reg2      (id_reg2),
    .id_uses_reg1 (id_uses_reg1),
    .id_uses_reg2 (id_uses_reg2),
    .id_is_ecall  (id_is_ecall),
    .ex_dest      (ex_dest),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .wb_ecall_done(wb_ecall_done),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_stall  (id_ex_stall),
    .ex_mem_stall (ex_mem_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .ecall_timeout(ecall_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  // ctl bits: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
  assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "[TB] aborted");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // c = {dmem_busy, ex_redirect, imem_busy, ex_mem_read, id_is_ecall, wb_ecall_done}
  task automatic drive(input logic [5:0] c);
    {dmem_busy, ex_redirect, imem_busy, ex_mem_read, id_is_ecall, wb_ecall_done} = c;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    id_reg1 = '0; id_reg2 = '0; ex_dest = '0;
    id_uses_reg1 = 1'b0; id_uses_reg2 = 1'b0;
    drive(6'b000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    id_reg1 = '0; id_reg2 = '0; ex_dest = '0;
    id_uses_reg1 = 1'b0; id_uses_reg2 = 1'b0;
    drive(6'b011010);
    tick();
    checks++;
    if (ctl !== 8'h00) $display("[TB] FAIL reset_ctl: got %h expected %h", ctl, 8'h00);
    else passes++;
    checks++;
    if (stall_cycles !== 4'd0) $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cycles);
    else passes++;
    checks++;
    if (flush_events !== 4'd0) $display("[TB] FAIL reset_flush_cnt: got %0d expected 0", flush_events);
    else passes++;
    checks++;
    if (ecall_timeout !== 1'b0) $display("[TB] FAIL reset_timeout: got %b expected 0", ecall_timeout);
    else passes++;
    do_reset();
  endtask

  task automatic test_load_use();
    // {ex_dest, id_reg1, id_reg2, uses1, uses2, ex_mem_read}
    logic [17:0] lu [6];
    logic [7:0]  ex [6];
    lu = '{{5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1},
           {5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0},
           {5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1},
           {5'd7, 5'd7, 5'd2, 1'b0, 1'b1, 1'b1},
           {5'd7, 5'd7, 5'd2, 1'b1, 1'b1, 1'b1},
           {5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1}};
    ex = '{8'hC4, 8'h00, 8'h00, 8'h00, 8'hC4, 8'h00};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {ex_dest, id_reg1, id_reg2, id_uses_reg1, id_uses_reg2, ex_mem_read} = lu[i];
      #1;
      checks++;
      if (ctl !== ex[i]) $display("[TB] FAIL load_use step %0d: got %h expected %h", i, ctl, ex[i]);
      else passes++;
      tick();
    end
    checks++;
    if (stall_cycles !== 4'd2) $display("[TB] FAIL load_use_stall_cnt: got %0d expected 2", stall_cycles);
    else passes++;
    checks++;
    if (flush_events !== 4'd2) $display("[TB] FAIL load_use_flush_cnt: got %0d expected 2", flush_events);
    else passes++;
  endtask

  task automatic test_redirect();
    logic [5:0] st [12];
    logic [7:0] ex [12];
    st = '{6'b011000, 6'b001000, 6'b001000, 6'b000000, 6'b000000, 6'b010000,
           6'b000000, 6'b011000, 6'b011000, 6'b001000, 6'b000000, 6'b000000};
    ex = '{8'h0C, 8'h88, 8'h88, 8'h08, 8'h00, 8'h0C,
           8'h00, 8'h0C, 8'h0C, 8'h88, 8'h08, 8'h00};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(st[i]);
      checks++;
      if (ctl !== ex[i]) $display("[TB] FAIL redirect step %0d: got %h expected %h", i, ctl, ex[i]);
      else passes++;
      tick();
    end
    checks++;
    if (stall_cycles !== 4'd3) $display("[TB] FAIL redirect_stall_cnt: got %0d expected 3", stall_cycles);
    else passes++;
    checks++;
    if (flush_events !== 4'd9) $display("[TB] FAIL redirect_flush_cnt: got %0d expected 9", flush_events);
    else passes++;
  endtask

  task automatic test_dmem_mask();
    logic [5:0] st [8];
    logic [7:0] ex [8];
    st = '{6'b111100, 6'b010000, 6'b000000, 6'b011000,
           6'b101000, 6'b001000, 6'b000000, 6'b000000};
    ex = '{8'hF1, 8'h0C, 8'h00, 8'h0C, 8'hF1, 8'h88, 8'h08, 8'h00};
    do_reset();
    ex_dest = 5'd5; id_reg2 = 5'd5; id_uses_reg2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(st[i]);
      checks++;
      if (ctl !== ex[i]) $display("[TB] FAIL dmem_mask step %0d: got %h expected %h", i, ctl, ex[i]);
      else passes++;
      tick();
    end
    id_uses_reg2 = 1'b0;
  endtask

  task automatic test_ecall();
    logic [5:0] st [7];
    logic [7:0] ex [7];
    st = '{6'b000010, 6'b000001, 6'b000000, 6'b000000, 6'b000001, 6'b000001, 6'b000000};
    ex = '{8'hC0, 8'hC4, 8'hC4, 8'hC4, 8'hC4, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      checks++;
      if (ctl !== ex[i]) $display("[TB] FAIL ecall step %0d: got %h expected %h", i, ctl, ex[i]);
      else passes++;
      tick();
    end
    checks++;
    if (stall_cycles !== 4'd5) $display("[TB] FAIL ecall_stall_cnt: got %0d expected 5", stall_cycles);
    else passes++;
    checks++;
    if (ecall_timeout !== 1'b0) $display("[TB] FAIL ecall_no_timeout: got %b expected 0", ecall_timeout);
    else passes++;
  endtask

  task automatic test_ecall_timeout();
    logic [5:0] st [10];
    logic [7:0] ex [10];
    logic       et [10];
    st = '{6'b000010, 6'b000000, 6'b000000, 6'b000000, 6'b100000,
           6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000};
    ex = '{8'hC0, 8'hC4, 8'hC4, 8'hC4, 8'hF1, 8'hC4, 8'hC4, 8'h00, 8'h00, 8'h88};
    et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(st[i]);
      checks++;
      if (ctl !== ex[i]) $display("[TB] FAIL timeout_ctl step %0d: got %h expected %h", i, ctl, ex[i]);
      else passes++;
      checks++;
      if (ecall_timeout !== et[i])
        $display("[TB] FAIL timeout_flag step %0d: got %b expected %b", i, ecall_timeout, et[i]);
      else passes++;
      tick();
    end
    drive(6'b000000);
  endtask

  // Runs straight after the timeout scenario so the sticky flag is still set.
  task automatic test_async_reset();
    drive(6'b000010);
    tick();
    drive(6'b000000);
    tick();
    checks++;
    if (ctl !== 8'hC4) $display("[TB] FAIL async_pre_wait: got %h expected %h", ctl, 8'hC4);
    else passes++;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== 8'h00) $display("[TB] FAIL async_ctl: got %h expected %h", ctl, 8'h00);
    else passes++;
    checks++;
    if (stall_cycles !== 4'd0) $display("[TB] FAIL async_stall_cnt: got %0d expected 0", stall_cycles);
    else passes++;
    checks++;
    if (flush_events !== 4'd0) $display("[TB] FAIL async_flush_cnt: got %0d expected 0", flush_events);
    else passes++;
    checks++;
    if (ecall_timeout !== 1'b0) $display("[TB] FAIL async_timeout: got %b expected 0", ecall_timeout);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (ctl !== 8'h00) $display("[TB] FAIL async_back_to_run: got %h expected %h", ctl, 8'h00);
    else passes++;
    drive(6'b001000);
    checks++;
    if (ctl !== 8'h88) $display("[TB] FAIL async_fetch_wait: got %h expected %h", ctl, 8'h88);
    else passes++;
    tick();
    drive(6'b000000);
    checks++;
    if (stall_cycles !== 4'd1) $display("[TB] FAIL async_recount: got %0d expected 1", stall_cycles);
    else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    drive(6'b001000);
    repeat (20) tick();
    checks++;
    if (stall_cycles !== 4'd15) $display("[TB] FAIL sat_stall_cnt: got %0d expected 15", stall_cycles);
    else passes++;
    checks++;
    if (flush_events !== 4'd15) $display("[TB] FAIL sat_flush_cnt: got %0d expected 15", flush_events);
    else passes++;
    drive(6'b000000);
    tick();
    checks++;
    if (stall_cycles !== 4'd15) $display("[TB] FAIL sat_hold: got %0d expected 15", stall_cycles);
    else passes++;
  endtask

  initial begin
    reset = 1'b0;
    $display("[TB] starting hazard_ctrl bench");
    test_reset();
    test_load_use();
    test_redirect();
    test_dmem_mask();
    test_ecall();
    test_ecall_timeout();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
